// File: rtl/pll_drp_sequencer.sv
// DRP reconfiguration sequencer: holds the PLL in reset, read-modify-writes a
// table of DRP registers from an external ROM, then releases reset and waits for lock.
module pll_drp_sequencer #(
   parameter int NUM_REGS     = 23,
   parameter int DRDY_TIMEOUT = 64,
   parameter int LOCK_IGNORE  = 2
) (
   input  logic        DCLK,
   input  logic        RST_N,
   input  logic        SEN,
   input  logic        SSEL,
   output logic        SRDY,
   output logic        BUSY,
   output logic        ERR,
   output logic [5:0]  ROM_ADDR,
   input  logic [38:0] ROM_DATA,
   output logic [6:0]  DADDR,
   output logic        DEN,
   output logic        DWE,
   output logic [15:0] DI,
   input  logic [15:0] DO,
   input  logic        DRDY,
   output logic        PLL_RST,
   input  logic        LOCKED
);

   localparam int TW = (DRDY_TIMEOUT < 2) ? 1 : $clog2(DRDY_TIMEOUT);
   localparam int LW = (LOCK_IGNORE < 2) ? 1 : $clog2(LOCK_IGNORE + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_READ, S_WAIT_R, S_MODIFY,
      S_WRITE, S_WAIT_W, S_RELEASE, S_WAIT_LOCK, S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic            sel_q, sel_d;
   logic [4:0]      idx_q, idx_d;
   logic            err_q, err_d;
   logic            pll_rst_q, pll_rst_d;
   logic            den_q, den_d;
   logic            dwe_q, dwe_d;
   logic [6:0]      addr_q, addr_d;
   logic [15:0]     mask_q, mask_d;
   logic [15:0]     data_q, data_d;
   logic [15:0]     rdata_q, rdata_d;
   logic [15:0]     di_q, di_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic [LW-1:0]   lcnt_q, lcnt_d;

   // DEN is registered, so den_q marks the DEN cycle; DRDY seen then is ignored.
   logic drdy_ok, tmo;
   assign drdy_ok = DRDY && !den_q;
   assign tmo     = (tcnt_q == TW'(DRDY_TIMEOUT - 1));

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      idx_d     = idx_q;
      err_d     = err_q;
      pll_rst_d = pll_rst_q;
      den_d     = 1'b0;
      dwe_d     = 1'b0;
      addr_d    = addr_q;
      mask_d    = mask_q;
      data_d    = data_q;
      rdata_d   = rdata_q;
      di_d      = di_q;
      tcnt_d    = tcnt_q;
      lcnt_d    = lcnt_q;
      case (state_q)
         S_IDLE: begin
            if (SEN) begin
               sel_d     = SSEL;
               idx_d     = '0;
               err_d     = 1'b0;
               pll_rst_d = 1'b1;
               state_d   = S_FETCH;
            end
         end
         S_FETCH: state_d = S_READ;
         S_READ: begin
            addr_d  = ROM_DATA[38:32];
            mask_d  = ROM_DATA[31:16];
            data_d  = ROM_DATA[15:0];
            den_d   = 1'b1;
            tcnt_d  = '0;
            state_d = S_WAIT_R;
         end
         S_WAIT_R: begin
            if (drdy_ok) begin
               rdata_d = DO;
               state_d = S_MODIFY;
            end else if (tmo) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         S_MODIFY: begin
            di_d    = (rdata_q & mask_q) | (data_q & ~mask_q);
            state_d = S_WRITE;
         end
         S_WRITE: begin
            den_d   = 1'b1;
            dwe_d   = 1'b1;
            tcnt_d  = '0;
            state_d = S_WAIT_W;
         end
         S_WAIT_W: begin
            if (drdy_ok) begin
               if (idx_q == 5'(NUM_REGS - 1)) begin
                  state_d = S_RELEASE;
               end else begin
                  idx_d   = idx_q + 5'd1;
                  state_d = S_FETCH;
               end
            end else if (tmo) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         S_RELEASE: begin
            pll_rst_d = 1'b0;
            lcnt_d    = LW'(LOCK_IGNORE);
            state_d   = S_WAIT_LOCK;
         end
         S_WAIT_LOCK: begin
            if (lcnt_q != '0) begin
               lcnt_d = lcnt_q - LW'(1);
            end else if (LOCKED) begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge DCLK) begin
      if (!RST_N) begin
         state_q   <= S_IDLE;
         sel_q     <= 1'b0;
         idx_q     <= '0;
         err_q     <= 1'b0;
         pll_rst_q <= 1'b0;
         den_q     <= 1'b0;
         dwe_q     <= 1'b0;
         addr_q    <= '0;
         mask_q    <= '0;
         data_q    <= '0;
         rdata_q   <= '0;
         di_q      <= '0;
         tcnt_q    <= '0;
         lcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         idx_q     <= idx_d;
         err_q     <= err_d;
         pll_rst_q <= pll_rst_d;
         den_q     <= den_d;
         dwe_q     <= dwe_d;
         addr_q    <= addr_d;
         mask_q    <= mask_d;
         data_q    <= data_d;
         rdata_q   <= rdata_d;
         di_q      <= di_d;
         tcnt_q    <= tcnt_d;
         lcnt_q    <= lcnt_d;
      end
   end

   assign SRDY     = (state_q == S_DONE);
   assign BUSY     = (state_q != S_IDLE) && (state_q != S_DONE);
   assign ERR      = err_q;
   assign ROM_ADDR = {sel_q, idx_q};
   assign DADDR    = addr_q;
   assign DEN      = den_q;
   assign DWE      = dwe_q;
   assign DI       = di_q;
   assign PLL_RST  = pll_rst_q;

endmodule
